// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
//   Definitions shared by the instruction-memory boot loader and its byte packer:
//   - the loader state encoding,
//   - the halt word, which terminates the stream and fills unused words,
//   - the default instruction-memory depth, which matches the instruction memory.
package imem_loader_pkg;

  localparam int          SIZE_IM_DEFAULT   = 128;
  localparam logic [31:0] HALT_WORD_DEFAULT = 32'hFC00_0000;

  typedef enum logic [2:0] {
    IDLE,
    RECV,
    WRITE,
    FILL,
    DONE
  } state_t;

endpackage

// File: rtl/imem_byte_packer.sv
// imem_byte_packer
//   Assembles big-endian 32-bit words from an accepted byte stream. The first
//   byte of each word lands in word[31:24].
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   clear       restart assembly at byte 0 (start of a new load)
//   accept      a byte is transferred this cycle
//   in_byte     the byte being transferred; it is sampled only when accept is high
//   word        assembly register; it holds the complete word in the cycle after word_valid
//   word_valid  high in the cycle that the fourth byte of a word is accepted
module imem_byte_packer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        accept,
  input  logic [7:0]  in_byte,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  byte_cnt_q;
  logic [31:0] shift_q;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the values from before the clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else if (clear) begin
      byte_cnt_q <= '0;
      shift_q    <= '0;
    end else if (accept) begin
      // The byte enters at the bottom. After four shifts, the first byte is in [31:24].
      shift_q    <= {shift_q[23:0], in_byte};
      byte_cnt_q <= byte_cnt_q + 2'd1;  // wraps mod 4 by width
    end
  end

  assign word       = shift_q;
  assign word_valid = accept && (byte_cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// imem_loader
//   Boot-time writer for the instruction memory. Receives a byte stream,
//   assembles big-endian words, and writes them to consecutive word addresses.
//   After a halt word, the remaining locations are padded with the halt word.
//   The processor is held in reset until the image is complete.
// Ports:
//   clk, rst_n       clock and asynchronous active-low reset
//   start            load request pulse; it is honoured only in IDLE and DONE
//   in_valid/in_data byte stream, valid/ready handshake with in_ready
//   we/waddr/wdata   instruction-memory write port (waddr is a byte address)
//   cpu_hold         keeps the processor in reset while high
//   done             the memory image is valid
//   word_count       number of stream words written (halt word included, fill excluded)
//   full             the memory was filled by stream words with no halt word
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          SIZE_IM   = SIZE_IM_DEFAULT,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEFAULT,
  localparam int         IW        = $clog2(SIZE_IM),
  localparam int         CW        = IW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  output logic          we,
  output logic [31:0]   waddr,
  output logic [31:0]   wdata,
  output logic          cpu_hold,
  output logic          done,
  output logic [CW-1:0] word_count,
  output logic          full
);

  localparam logic [IW-1:0] LAST_IDX = IW'(SIZE_IM - 1);

  state_t          state_q, state_d;
  logic [IW-1:0]   index_q;
  logic [CW-1:0]   word_count_q;
  logic            full_q;
  logic            done_q;
  logic            hold_q;
  logic            clear_load;
  logic            accept;
  logic            word_valid;
  logic [31:0]     word;
  logic            last_idx;
  logic            is_halt;

  assign accept   = in_valid && in_ready;
  assign last_idx = (index_q == LAST_IDX);
  assign is_halt  = (word == HALT_WORD);

  imem_byte_packer u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (clear_load),
    .accept     (accept),
    .in_byte    (in_data),
    .word       (word),
    .word_valid (word_valid)
  );

  // Next-state logic.
  // NOTE: every signal assigned here gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    clear_load = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d    = RECV;
          clear_load = 1'b1;
        end
      end
      RECV: begin
        if (word_valid) state_d = WRITE;
      end
      WRITE: begin
        // The last index ends the load whether or not the word is a halt word.
        if (last_idx)     state_d = DONE;
        else if (is_halt) state_d = FILL;
        else              state_d = RECV;
      end
      FILL: begin
        if (last_idx) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      index_q      <= '0;
      word_count_q <= '0;
      full_q       <= 1'b0;
      done_q       <= 1'b0;
      hold_q       <= 1'b1;
    end else begin
      state_q <= state_d;
      // done and cpu_hold follow the next state, so they are registered and
      // change exactly on entry to or exit from DONE.
      done_q  <= (state_d == DONE);
      hold_q  <= (state_d != DONE);
      if (clear_load) begin
        index_q      <= '0;
        word_count_q <= '0;
        full_q       <= 1'b0;
      end else begin
        // The index stops at the last word and never wraps.
        if ((state_q == WRITE || state_q == FILL) && !last_idx)
          index_q <= index_q + 1'b1;
        if (state_q == WRITE) begin
          word_count_q <= word_count_q + 1'b1;
          if (last_idx && !is_halt) full_q <= 1'b1;
        end
      end
    end
  end

  // The write-port outputs are decoded from the state register. Because the
  // state register resets asynchronously, we drops as soon as rst_n falls.
  always_comb begin
    wdata = '0;
    unique case (state_q)
      WRITE:   wdata = word;
      FILL:    wdata = HALT_WORD;
      default: wdata = '0;
    endcase
  end

  assign in_ready   = (state_q == RECV);
  assign we         = (state_q == WRITE) || (state_q == FILL);
  assign waddr      = {{(30-IW){1'b0}}, index_q, 2'b00};
  assign cpu_hold   = hold_q;
  assign done       = done_q;
  assign word_count = word_count_q;
  assign full       = full_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Self-checking bench for imem_loader. Two instances, with SIZE_IM=8 and
//   SIZE_IM=4, share the byte stream; only the selected instance is started.
//   Expected write sequences come from a word-level model of the load rules.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam logic [31:0] HALT = 32'hFC00_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start8 = 1'b0, start4 = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;

  logic        rdy8, we8, hold8, done8, full8;
  logic [31:0] waddr8, wdata8;
  logic [3:0]  wc8;
  logic        rdy4, we4, hold4, done4, full4;
  logic [31:0] waddr4, wdata4;
  logic [2:0]  wc4;

  imem_loader #(.SIZE_IM(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy8), .we(we8), .waddr(waddr8), .wdata(wdata8), .cpu_hold(hold8),
    .done(done8), .word_count(wc8), .full(full8)
  );

  imem_loader #(.SIZE_IM(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .in_valid(in_valid), .in_data(in_data),
    .in_ready(rdy4), .we(we4), .waddr(waddr4), .wdata(wdata4), .cpu_hold(hold4),
    .done(done4), .word_count(wc4), .full(full4)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit sel4    = 1'b0;

  logic [63:0] wrq[$];  // observed writes {waddr, wdata}

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic cur_rdy();  return sel4 ? rdy4  : rdy8;  endfunction
  function automatic logic cur_done(); return sel4 ? done4 : done8; endfunction
  function automatic logic cur_hold(); return sel4 ? hold4 : hold8; endfunction
  function automatic logic cur_full(); return sel4 ? full4 : full8; endfunction
  function automatic int   cur_wc();   return sel4 ? int'(wc4) : int'(wc8); endfunction

  // Record every write and check that the write port and the stream are never active together.
  always @(negedge clk) begin
    if (we8) begin
      wrq.push_back({waddr8, wdata8});
      check("rdy8_during_write", {63'd0, rdy8}, 64'd0);
    end
    if (we4) begin
      wrq.push_back({waddr4, wdata4});
      check("rdy4_during_write", {63'd0, rdy4}, 64'd0);
    end
  end

  // Word-level reference. Stream words go to addresses 0,4,8,... until a halt
  // word or the last location. After a halt word, the remaining locations hold HALT.
  task automatic model(input int size, input logic [31:0] w[$],
                       output logic [63:0] exp[$], output int used, output bit full_e);
    bit halted = 1'b0;
    exp.delete();
    used   = 0;
    full_e = 1'b0;
    for (int k = 0; k < size && k < w.size(); k++) begin
      exp.push_back({32'(k * 4), w[k]});
      used++;
      if (w[k] == HALT) begin
        halted = 1'b1;
        break;
      end
    end
    if (halted) begin
      for (int j = used; j < size; j++) exp.push_back({32'(j * 4), HALT});
    end else if (used == size) begin
      full_e = 1'b1;
    end
  endtask

  task automatic send(input logic [7:0] b[$], input bit rnd, input string tag);
    int i = 0;
    int guard = 0;
    while (i < b.size() && guard < 2000) begin
      logic v;
      @(negedge clk);
      guard++;
      v        = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      in_valid = v;
      in_data  = v ? b[i] : 8'($urandom);
      if (v && cur_rdy()) i++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    check({tag, "_bytes_sent"}, 64'(i), 64'(b.size()));
  endtask

  task automatic pulse_start(input bit d4);
    @(negedge clk);
    start8 = !d4;
    start4 = d4;
    @(negedge clk);
    start8 = 1'b0;
    start4 = 1'b0;
  endtask

  task automatic to_bytes(input logic [31:0] w[$], input int n, output logic [7:0] b[$]);
    b.delete();
    for (int k = 0; k < n; k++) begin
      b.push_back(w[k][31:24]);
      b.push_back(w[k][23:16]);
      b.push_back(w[k][15:8]);
      b.push_back(w[k][7:0]);
    end
  endtask

  // One complete load. When mid_start is set, start is pulsed after two bytes.
  task automatic run_load(input bit d4, input logic [31:0] w[$], input bit rnd,
                          input bit mid_start, input string tag);
    logic [63:0] exp[$];
    logic [7:0]  b[$];
    logic [7:0]  b1[$];
    logic [7:0]  b2[$];
    int          used;
    bit          full_e;
    sel4 = d4;
    model(d4 ? 4 : 8, w, exp, used, full_e);
    to_bytes(w, used, b);
    wrq.delete();
    pulse_start(d4);
    check({tag, "_hold_after_start"}, {63'd0, cur_hold()}, 64'd1);
    check({tag, "_done_after_start"}, {63'd0, cur_done()}, 64'd0);
    check({tag, "_rdy_after_start"},  {63'd0, cur_rdy()},  64'd1);
    if (mid_start) begin
      b1 = b[0:1];
      b2 = b[2:$];
      send(b1, rnd, tag);
      pulse_start(d4);
      send(b2, rnd, tag);
    end else begin
      send(b, rnd, tag);
    end
    for (int c = 0; c < 400 && !cur_done(); c++) @(negedge clk);
    check({tag, "_done"},       {63'd0, cur_done()}, 64'd1);
    check({tag, "_hold"},       {63'd0, cur_hold()}, 64'd0);
    check({tag, "_word_count"}, 64'(cur_wc()),       64'(used));
    check({tag, "_full"},       {63'd0, cur_full()}, {63'd0, full_e});
    check({tag, "_num_writes"}, 64'(wrq.size()),     64'(exp.size()));
    for (int k = 0; k < exp.size() && k < wrq.size(); k++)
      check($sformatf("%s_write%0d", tag, k), wrq[k], exp[k]);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy"},   {63'd0, rdy8},  64'd0);
    check({tag, "_we"},    {63'd0, we8},   64'd0);
    check({tag, "_waddr"}, 64'(waddr8),    64'd0);
    check({tag, "_wdata"}, 64'(wdata8),    64'd0);
    check({tag, "_done"},  {63'd0, done8}, 64'd0);
    check({tag, "_hold"},  {63'd0, hold8}, 64'd1);
    check({tag, "_wc"},    64'(wc8),       64'd0);
    check({tag, "_full"},  {63'd0, full8}, 64'd0);
  endtask

  initial begin
    logic [31:0] ws[$];
    logic [7:0]  bs[$];

    repeat (2) @(negedge clk);
    check_reset_outputs("reset8");
    check("reset4_hold", {63'd0, hold4}, 64'd1);
    check("reset4_we",   {63'd0, we4},   64'd0);
    rst_n = 1'b1;

    // Basic two-word image with a halt word, on the 8-word memory.
    ws.delete(); ws.push_back(32'h2008_0005); ws.push_back(HALT);
    run_load(1'b0, ws, 1'b0, 1'b0, "basic");
    // Same stream with random valid gaps, started from DONE.
    run_load(1'b0, ws, 1'b1, 1'b0, "gappy");
    // Reload from DONE with only a halt word.
    ws.delete(); ws.push_back(HALT);
    run_load(1'b0, ws, 1'b1, 1'b0, "halt_only");

    // Four non-halt words fill the 4-word memory.
    ws.delete();
    for (int k = 1; k <= 4; k++) ws.push_back(32'(k));
    run_load(1'b1, ws, 1'b0, 1'b0, "full4");
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'h5A;
      check("full4_no_accept", {63'd0, rdy4}, 64'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    check("full4_wc_stable", 64'(wc4), 64'd4);

    // A start pulse in the middle of a word has no effect.
    ws.delete(); ws.push_back(32'h0A0B_0C0D); ws.push_back(32'h1111_2222); ws.push_back(HALT);
    run_load(1'b0, ws, 1'b1, 1'b1, "mid_start");

    // Reset after six bytes of a load.
    sel4 = 1'b0;
    pulse_start(1'b0);
    ws.delete(); ws.push_back(32'h1122_3344); ws.push_back(32'hAABB_CCDD);
    to_bytes(ws, 2, bs);
    bs = bs[0:5];
    send(bs, 1'b0, "rst6");
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst6_async");
    @(negedge clk);
    rst_n = 1'b1;
    ws.delete(); ws.push_back(HALT);
    run_load(1'b0, ws, 1'b0, 1'b0, "after_rst");

    // Reset during a WRITE cycle: we must fall immediately.
    pulse_start(1'b0);
    ws.delete(); ws.push_back(32'h1234_5678);
    to_bytes(ws, 1, bs);
    send(bs, 1'b0, "rstw");
    check("rstw_we_before", {63'd0, we8}, 64'd1);
    #2 rst_n = 1'b0;
    #1 check("rstw_we_async", {63'd0, we8}, 64'd0);
    check("rstw_hold_async", {63'd0, hold8}, 64'd1);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized images: even iterations contain a halt word; odd iterations fill the memory.
    for (int it = 0; it < 8; it++) begin
      int n;
      ws.delete();
      n = (it % 2 == 0) ? int'($urandom_range(1, 10)) : int'($urandom_range(8, 10));
      for (int k = 0; k < n; k++) begin
        logic [31:0] r;
        r = $urandom;
        if (r == HALT) r = 32'h0;
        ws.push_back(r);
      end
      if (it % 2 == 0) ws[$urandom_range(0, n - 1)] = HALT;
      run_load(1'b0, ws, 1'b1, 1'b0, $sformatf("rand%0d", it));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
